// File: rtl/core_div_iter.sv
// core_div_iter: iterative Newton-Raphson posit mantissa divider; define DIV_EARLY_EXIT_EN for the divide-by-1.0 fast path
module core_div_iter #(
  parameter int N = 16,
  parameter int NR_ITERS = 2,
  localparam int ES = 1,
  localparam int MANT_SIZE = N - 2,
  localparam int TE_SIZE = ES + $clog2(N) + 2,
  localparam int MANT_DIV_RESULT_SIZE = 3 * MANT_SIZE - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [TE_SIZE-1:0]              te1,
  input  logic [TE_SIZE-1:0]              te2,
  input  logic [MANT_SIZE-1:0]            mant1,
  input  logic [MANT_SIZE-1:0]            mant2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MANT_DIV_RESULT_SIZE-1:0] mant_out,
  output logic [TE_SIZE-1:0]              te_out,
  output logic                            div_err
);
  localparam int M = MANT_SIZE;
  localparam int XW = 2 * M;
  localparam int PW = 3 * M;
  localparam int RW = MANT_DIV_RESULT_SIZE;
  localparam logic [M-1:0] ONE_M = {1'b1, {(M-1){1'b0}}};
  localparam logic [XW-1:0] ONE_X = {1'b1, {(XW-1){1'b0}}};
  localparam logic [PW-1:0] TWO_P = {1'b1, {(PW-1){1'b0}}};
  localparam logic [XW-1:0] C24 = XW'((64'd24 << (XW - 1)) / 64'd17);
  localparam logic [XW-1:0] K8 = XW'((64'd8 << (XW - 1)) / 64'd17);
  localparam logic [2:0] LAST = 3'(NR_ITERS - 1);
  typedef enum logic [2:0] {IDLE, SEED, ITER, MUL, DONE} state_t;
  state_t st, nxt;
  logic [TE_SIZE-1:0] te1_r, te2_r, te_diff;
  logic [M-1:0] m1_r, d_r;
  logic [XW-1:0] x_r, seed, x_next;
  logic [2:0] cnt;
  logic [M+XW-1:0] lin;
  logic [PW-1:0] t, e, qf;
  logic [XW+PW-1:0] p;
  logic [RW-1:0] q;
  logic skip, bad;
`ifdef DIV_EARLY_EXIT_EN
  assign skip = d_r == ONE_M;
`else
  assign skip = 1'b0;
`endif
  assign bad = ~d_r[M-1];
  always_comb begin
    lin = {{XW{1'b0}}, d_r} * {{M{1'b0}}, K8};
    seed = d_r == ONE_M ? ONE_X : C24 - XW'(lin >> (M - 1));
    t = {{XW{1'b0}}, d_r} * {{M{1'b0}}, x_r};
    e = TWO_P - t;
    p = {{PW{1'b0}}, x_r} * {{XW{1'b0}}, e};
    x_next = XW'(p >> (PW - 2));
    qf = {{XW{1'b0}}, m1_r} * {{M{1'b0}}, x_r};
    q = RW'(qf);
    te_diff = te1_r - te2_r;
  end
  always_comb begin
    nxt = st;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        nxt = in_valid ? SEED : IDLE;
      end
      SEED: nxt = skip ? MUL : ITER;
      ITER: nxt = cnt == LAST ? MUL : ITER;
      MUL: nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        nxt = out_ready ? IDLE : DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    st <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      te1_r <= '0;
      te2_r <= '0;
      m1_r <= '0;
      d_r <= '0;
      x_r <= '0;
      cnt <= '0;
      mant_out <= '0;
      te_out <= '0;
      div_err <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        te1_r <= te1;
        te2_r <= te2;
        m1_r <= mant1;
        d_r <= mant2;
      end
      if (st == SEED) begin
        x_r <= seed;
        cnt <= '0;
      end
      if (st == ITER) begin
        x_r <= x_next;
        cnt <= cnt + 3'd1;
      end
      if (st == MUL) begin
        div_err <= bad;
        mant_out <= bad ? '0 : q[RW-1] ? q : q << 1;
        te_out <= bad || q[RW-1] ? te_diff : te_diff - TE_SIZE'(1);
      end
    end
  end
endmodule

// File: tb/tb_core_div_iter.sv
// tb_core_div_iter: directed table, handshake/reset sequences and random sweep of NR_ITERS 1..4 against an exact-division model
module tb_core_div_iter;
  localparam int M = 14;
  localparam int TW = 7;
  localparam int RW = 41;
  typedef struct {
    logic [M-1:0]  m1;
    logic [M-1:0]  m2;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [RW-1:0] mant;
    logic [TW-1:0] te;
    logic          err;
    logic          exact;
  } vec_t;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [TW-1:0] te1, te2;
  logic [M-1:0] mant1, mant2;
  logic [3:0] rdy, vld, err_o, ordy;
  logic [RW-1:0] mant_o [4];
  logic [TW-1:0] te_o [4];
  logic [RW-1:0] cap_mant [4];
  logic [TW-1:0] cap_te [4];
  logic [3:0] cap_err;
  int cap_lat [4];
  int checks = 0;
  int fails = 0;
  vec_t tbl [8];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    core_div_iter #(.N(16), .NR_ITERS(g + 1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]),
      .te1(te1), .te2(te2), .mant1(mant1), .mant2(mant2),
      .out_valid(vld[g]), .out_ready(ordy[g]),
      .mant_out(mant_o[g]), .te_out(te_o[g]), .div_err(err_o[g])
    );
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h +/- %0d", nm, act, exp, tol);
    end
  endtask
  task automatic check_model(input int g, input logic [M-1:0] m1, input logic [M-1:0] m2,
                             input logic [TW-1:0] t1, input logic [TW-1:0] t2);
    logic [TW-1:0] td, te_e, te_lo;
    longint r, ex, tol, top;
    td = t1 - t2;
    chk($sformatf("err_flag[%0d]", g), cap_err[g], !m2[M-1]);
    if (!m2[M-1]) begin
      chk($sformatf("err_mant[%0d]", g), cap_mant[g], 0);
      chk($sformatf("err_te[%0d]", g), cap_te[g], td);
    end else begin
      tol = g == 0 ? 256 : 1;
      r = (longint'(m1) << 16) / longint'(m2);
      ex = r >= 65536 ? (longint'(m1) << 15) / longint'(m2) : r;
      te_e = r >= 65536 ? td : td - 7'd1;
      te_lo = te_e - 7'd1;
      top = longint'(cap_mant[g][RW-1 -: 16]);
      chk($sformatf("norm[%0d]", g), cap_mant[g][RW-1], 1);
      if (cap_te[g] == te_e) chk_tol($sformatf("quot[%0d] %h/%h", g, m1, m2), top, ex, tol);
      else if (cap_te[g] == te_lo) chk_tol($sformatf("quot_lo[%0d] %h/%h", g, m1, m2), top, 2 * ex, 2 * tol);
      else chk($sformatf("quot_te[%0d] %h/%h", g, m1, m2), cap_te[g], te_e);
    end
  endtask
  task automatic run_op(input logic [M-1:0] m1, input logic [M-1:0] m2,
                        input logic [TW-1:0] t1, input logic [TW-1:0] t2);
    logic [3:0] got;
    int exp_lat;
    @(negedge clk);
    chk("in_ready_idle", rdy, 4'hF);
    mant1 = m1;
    mant2 = m2;
    te1 = t1;
    te2 = t2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = '0;
    for (int c = 1; c <= 12 && got != 4'hF; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++)
        if (!got[g] && vld[g]) begin
          got[g] = 1'b1;
          cap_mant[g] = mant_o[g];
          cap_te[g] = te_o[g];
          cap_err[g] = err_o[g];
          cap_lat[g] = c;
        end
    end
    chk("all_done", got, 4'hF);
    for (int g = 0; g < 4; g++)
      if (got[g]) begin
        exp_lat = g + 3;
`ifdef DIV_EARLY_EXIT_EN
        if (m2 == 14'h2000) exp_lat = 2;
`endif
        chk($sformatf("latency[%0d]", g), cap_lat[g], exp_lat);
        check_model(g, m1, m2, t1, t2);
      end
    @(posedge clk);
    #1 chk("valid_after_hs", vld, 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [RW-1:0] cm;
    logic [TW-1:0] ct;
    logic seen;
    tbl[0] = '{14'h2000, 14'h2000, 7'd5, 7'd2, {1'b1, 40'd0}, 7'd3, 1'b0, 1'b1};
    tbl[1] = '{14'h2000, 14'h3000, 7'd0, 7'd0, {16'hAAAA, 25'd0}, 7'h7F, 1'b0, 1'b0};
    tbl[2] = '{14'h3800, 14'h2800, 7'h78, 7'd7, {16'hB333, 25'd0}, 7'h71, 1'b0, 1'b0};
    tbl[3] = '{14'h3000, 14'h0000, 7'd3, 7'd1, 41'd0, 7'd2, 1'b1, 1'b1};
    tbl[4] = '{14'h3000, 14'h1FFF, 7'd0, 7'd0, 41'd0, 7'd0, 1'b1, 1'b1};
    tbl[5] = '{14'h2000, 14'h2000, 7'h3F, 7'h40, {1'b1, 40'd0}, 7'h7F, 1'b0, 1'b1};
    tbl[6] = '{14'h2000, 14'h3000, 7'h40, 7'h01, {16'hAAAA, 25'd0}, 7'h3E, 1'b0, 1'b0};
    tbl[7] = '{14'h3FFF, 14'h2000, 7'h0A, 7'h0C, {14'h3FFF, 27'd0}, 7'h7E, 1'b0, 1'b1};
    rst = 1'b1;
    in_valid = 1'b0;
    ordy = 4'hF;
    mant1 = '0;
    mant2 = '0;
    te1 = '0;
    te2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", rdy, 4'hF);
    chk("rst_valid", vld, 0);
    chk("rst_err", err_o, 0);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_mant[%0d]", g), mant_o[g], 0);
      chk($sformatf("rst_te[%0d]", g), te_o[g], 0);
    end
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].m1, tbl[i].m2, tbl[i].t1, tbl[i].t2);
      chk($sformatf("tbl%0d_err", i), cap_err[1], tbl[i].err);
      chk($sformatf("tbl%0d_te", i), cap_te[1], tbl[i].te);
      if (tbl[i].exact) chk($sformatf("tbl%0d_mant", i), cap_mant[1], tbl[i].mant);
      else chk_tol($sformatf("tbl%0d_top", i), cap_mant[1][RW-1 -: 16], tbl[i].mant[RW-1 -: 16], 1);
    end
    ordy = 4'h0;
    @(negedge clk);
    mant1 = 14'h3800;
    mant2 = 14'h2800;
    te1 = 7'h78;
    te2 = 7'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 12 && !vld[1]; c++) begin
      @(posedge clk);
      #1;
    end
    chk("hold_seen", vld[1], 1);
    cm = mant_o[1];
    ct = te_o[1];
    cap_mant[1] = cm;
    cap_te[1] = ct;
    cap_err[1] = err_o[1];
    check_model(1, 14'h3800, 14'h2800, 7'h78, 7'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mant1 = 14'h2000;
      mant2 = 14'h2000;
      te1 = 7'd1;
      te2 = 7'd0;
      @(posedge clk);
      #1;
      chk("hold_valid", vld[1], 1);
      chk("hold_ready", rdy[1], 0);
      chk("hold_mant", mant_o[1], cm);
      chk("hold_te", te_o[1], ct);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ordy = 4'hF;
    @(posedge clk);
    #1;
    chk("hs_valid", vld[1], 0);
    chk("hs_ready", rdy[1], 1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen |= |vld;
    end
    chk("no_second_accept", seen, 0);
    @(negedge clk);
    mant1 = 14'h3800;
    mant2 = 14'h2800;
    te1 = 7'd4;
    te2 = 7'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", vld, 0);
    chk("midrst_ready", rdy, 4'hF);
    chk("midrst_mant", mant_o[1], 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen |= |vld;
    end
    chk("midrst_no_result", seen, 0);
    run_op(14'h3800, 14'h2800, 7'd4, 7'd1);
    for (int i = 0; i < 1000; i++)
      run_op({1'b1, 13'($urandom)}, i % 50 == 0 ? 14'h2000 : {1'b1, 13'($urandom)},
             7'($urandom), 7'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
